// File: rtl/pio_svc_pkg.sv
// rtl/pio_svc_pkg.sv - shared types, register map and helpers for the PIO irq servicer
package pio_svc_pkg;

    typedef enum logic [3:0] {
        S_INIT,
        S_IDLE,
        S_WR_MASK,
        S_RD_CAP,
        S_CAP_WAIT,
        S_CLR_CAP,
        S_RD_DAT,
        S_DAT_WAIT,
        S_EMIT
    } state_t;

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_CAP  = 2'd3;

    localparam int MAX_IDX_W = 5;

    typedef struct packed {
        logic [MAX_IDX_W-1:0] index;
        logic                 level;
    } event_t;

    // Index of the least significant set bit; 0 when nothing is set.
    function automatic logic [MAX_IDX_W-1:0] lowest_set(input logic [31:0] v);
        lowest_set = '0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) lowest_set = MAX_IDX_W'(i);
        end
    endfunction

endpackage

// File: rtl/event_fifo.sv
// rtl/event_fifo.sv - synchronous FIFO with push/pop, full/empty and registered storage
module event_fifo #(
    parameter int DATA_W = 3,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_push,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_pop,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    output logic              o_full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;
    logic              w_pop;
    logic              w_push;

    assign o_valid = (r_count != '0);
    assign o_full  = (r_count == FULL_CNT);
    assign o_data  = r_mem[r_rd_ptr];
    assign w_pop   = i_pop && o_valid;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    assign w_push  = i_push && (!o_full || w_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (PTR_W+1)'(1);
                2'b01:   r_count <= r_count - (PTR_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pio_irq_servicer.sv
// rtl/pio_irq_servicer.sv - Avalon-MM master that services the edge-capture PIO and queues events
module pio_irq_servicer
    import pio_svc_pkg::*;
#(
    parameter int               WIDTH      = 3,
    parameter int               FIFO_DEPTH = 8,
    parameter logic [WIDTH-1:0] INIT_MASK  = 3'b111,
    parameter int               IDX_W      = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    output logic [1:0]        m_address,
    output logic              m_chipselect,
    output logic              m_write_n,
    output logic [31:0]       m_writedata,
    input  logic [31:0]       m_readdata,
    input  logic              irq,
    input  logic [WIDTH-1:0]  cfg_mask,
    input  logic              cfg_mask_wr,
    output logic              ev_valid,
    input  logic              ev_ready,
    output logic [IDX_W-1:0]  ev_index,
    output logic              ev_level,
    output logic              overflow
);

    state_t             r_state;
    state_t             w_next;
    logic [WIDTH-1:0]   r_cap;
    logic [WIDTH-1:0]   r_lvl;
    logic [WIDTH-1:0]   r_mask_pend;
    logic               r_req_pend;
    logic               r_overflow;
    logic [WIDTH-1:0]   w_cap_next;
    event_t             w_ev;
    logic               w_push;
    logic               w_full;
    logic [IDX_W:0]     w_fifo_dout;
    logic               w_unused;

    assign w_cap_next = r_cap & (r_cap - WIDTH'(1));
    assign overflow   = r_overflow;
    assign ev_index   = w_fifo_dout[IDX_W:1];
    assign ev_level   = w_fifo_dout[0];
    assign w_unused   = ^{m_readdata[31:WIDTH], w_ev.index[MAX_IDX_W-1:IDX_W]};

    always_comb begin
        w_ev       = '0;
        w_ev.index = lowest_set(32'(r_cap));
        w_ev.level = r_lvl[w_ev.index[IDX_W-1:0]];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_INIT;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:     w_next = S_IDLE;
            S_IDLE: begin
                if (cfg_mask_wr || r_req_pend) w_next = S_WR_MASK;
                else if (irq)                  w_next = S_RD_CAP;
            end
            S_WR_MASK:  w_next = S_IDLE;
            S_RD_CAP:   w_next = S_CAP_WAIT;
            S_CAP_WAIT: w_next = (m_readdata[WIDTH-1:0] == '0) ? S_IDLE : S_CLR_CAP;
            S_CLR_CAP:  w_next = S_RD_DAT;
            S_RD_DAT:   w_next = S_DAT_WAIT;
            S_DAT_WAIT: w_next = S_EMIT;
            S_EMIT:     if (w_push && w_cap_next == '0) w_next = S_IDLE;
            default:    w_next = S_INIT;
        endcase
    end

    // The INIT write is held off while reset is asserted so the bus is quiet during reset.
    always_comb begin
        m_chipselect = 1'b0;
        m_write_n    = 1'b1;
        m_address    = ADDR_DATA;
        m_writedata  = '0;
        w_push       = 1'b0;
        case (r_state)
            S_INIT: if (reset_n) begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = ADDR_MASK;
                m_writedata  = 32'(INIT_MASK);
            end
            S_WR_MASK: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = ADDR_MASK;
                m_writedata  = 32'(r_mask_pend);
            end
            S_RD_CAP: begin
                m_chipselect = 1'b1;
                m_address    = ADDR_CAP;
            end
            S_CAP_WAIT: m_address = ADDR_CAP;
            S_CLR_CAP: begin
                m_chipselect = 1'b1;
                m_write_n    = 1'b0;
                m_address    = ADDR_CAP;
            end
            S_RD_DAT:   m_chipselect = 1'b1;
            S_EMIT:     w_push = !w_full || ev_ready;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cap       <= '0;
            r_lvl       <= '0;
            r_mask_pend <= INIT_MASK;
            r_req_pend  <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (r_state == S_CAP_WAIT) r_cap <= m_readdata[WIDTH-1:0];
            else if (w_push)           r_cap <= w_cap_next;
            if (r_state == S_DAT_WAIT) r_lvl <= m_readdata[WIDTH-1:0];
            if (cfg_mask_wr) r_mask_pend <= cfg_mask;
            if (cfg_mask_wr && r_req_pend) r_overflow <= 1'b1;
            if (r_state == S_IDLE && (cfg_mask_wr || r_req_pend)) r_req_pend <= 1'b0;
            else if (cfg_mask_wr)                                 r_req_pend <= 1'b1;
        end
    end

    event_fifo #(
        .DATA_W (IDX_W + 1),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .i_push  (w_push),
        .i_data  ({w_ev.index[IDX_W-1:0], w_ev.level}),
        .i_pop   (ev_ready),
        .o_data  (w_fifo_dout),
        .o_valid (ev_valid),
        .o_full  (w_full)
    );

endmodule
